// File: rtl/traffic_light.sv
// traffic_light: three-phase red/green/yellow lamp sequencer with per-phase enabled-cycle durations.
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset (forces red, count 0)
//   enable     high advances the phase timer, low freezes state and timer
//   red        red lamp (also shown for the illegal state encoding)
//   yellow     yellow lamp
//   green      green lamp
//   count_out  [5:0] internal phase counter, present only with TRAFFIC_LIGHT_COUNT_OUT_EN defined
module traffic_light #(
  parameter int unsigned RED_CYCLES    = 32,
  parameter int unsigned GREEN_CYCLES  = 20,
  parameter int unsigned YELLOW_CYCLES = 7
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  output logic       red,
  output logic       yellow,
  output logic       green
`ifdef TRAFFIC_LIGHT_COUNT_OUT_EN
  ,
  output logic [5:0] count_out
`endif
);
  typedef enum logic [1:0] {S_RED = 2'b00, S_GREEN = 2'b01, S_YELLOW = 2'b10} state_e;
  localparam logic [5:0] RED_LAST    = 6'(RED_CYCLES - 1);
  localparam logic [5:0] GREEN_LAST  = 6'(GREEN_CYCLES - 1);
  localparam logic [5:0] YELLOW_LAST = 6'(YELLOW_CYCLES - 1);
  state_e     state;
  logic [5:0] count_q;
  logic [5:0] last;
  logic       legal;
  state_e     state_next;
  always_comb begin
    last       = state == S_GREEN ? GREEN_LAST : state == S_YELLOW ? YELLOW_LAST : RED_LAST;
    legal      = state != state_e'(2'b11);
    state_next = state == S_RED ? S_GREEN : state == S_GREEN ? S_YELLOW : S_RED;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_RED;
      count_q <= '0;
    end else if (!legal) begin
      state   <= S_RED;
      count_q <= '0;
    end else if (enable) begin
      if (count_q == last) begin
        state   <= state_next;
        count_q <= '0;
      end else begin
        count_q <= count_q + 6'd1;
      end
    end
  end
  // Red is the fallback lamp so the illegal encoding still shows exactly one lamp.
  assign green  = state == S_GREEN;
  assign yellow = state == S_YELLOW;
  assign red    = !green && !yellow;
`ifdef TRAFFIC_LIGHT_COUNT_OUT_EN
  assign count_out = count_q;
`endif
endmodule

// File: tb/tb_traffic_light.sv
// tb_traffic_light: self-checking bench for traffic_light against a phase/elapsed-time model.
module tb_traffic_light;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic red, yellow, green;
`ifdef TRAFFIC_LIGHT_COUNT_OUT_EN
  logic [5:0] count_out;
`endif
  int total = 0;
  int bad = 0;
  int ph = 0;
  int el = 0;
  int changes = 0;
  int dur[3] = '{32, 20, 7};

  traffic_light dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .red(red),
    .yellow(yellow),
    .green(green)
`ifdef TRAFFIC_LIGHT_COUNT_OUT_EN
    ,
    .count_out(count_out)
`endif
  );

  always #5 clk = ~clk;

  // Model: a phase lasts dur[ph] enabled edges, then the next phase in order begins.
  task automatic step();
    @(posedge clk);
    if (enable && reset_n) begin
      el++;
      if (el == dur[ph]) begin
        el = 0;
        ph = (ph + 1) % 3;
        changes++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    ph = 0;
    el = 0;
    repeat (3) step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    enable = 1'b0;
    reset_n = 1'b0;
    ph = 0;
    el = 0;
    repeat (2) step();
    total++;
    if ({red, yellow, green} !== 3'b100) begin
      bad++;
      $display("FAIL reset_lamps: got %b want 100", {red, yellow, green});
    end
    reset_n = 1'b1;
    total++;
    if (dut.state !== 2'b00) begin
      bad++;
      $display("FAIL reset_state: got %b want 00", dut.state);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if (dut.state !== 2'b00 || {red, yellow, green} !== 3'b100) begin
        bad++;
        $display("FAIL idle_hold: cycle %0d got state=%b lamps=%b want state=00 lamps=100", i, dut.state, {red, yellow, green});
      end
    end
  endtask

  task automatic test_full_cycle();
    logic [2:0] want;
    do_reset();
    enable = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      step();
      want = n < 32 ? 3'b100 : n < 52 ? 3'b001 : n < 59 ? 3'b010 : 3'b100;
      total++;
      if ({red, yellow, green} !== want || dut.state !== 2'(ph)) begin
        bad++;
        $display("FAIL full_cycle: edge %0d got lamps=%b state=%b want lamps=%b state=%0d", n, {red, yellow, green}, dut.state, want, ph);
      end
    end
  endtask

  task automatic test_pause();
    int n;
    do_reset();
    enable = 1'b1;
    n = 0;
    while (!(ph == 1 && el == 10) && n < 100) begin
      step();
      n++;
    end
    total++;
    if (green !== 1'b1) begin
      bad++;
      $display("FAIL pause_setup: got green=%b want 1", green);
    end
    enable = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      total++;
      if (green !== 1'b1 || dut.state !== 2'b01) begin
        bad++;
        $display("FAIL pause_hold: cycle %0d got green=%b state=%b want 1 01", i, green, dut.state);
      end
`ifdef TRAFFIC_LIGHT_COUNT_OUT_EN
      total++;
      if (count_out !== 6'd10) begin
        bad++;
        $display("FAIL pause_count: got %0d want 10", count_out);
      end
`endif
    end
    enable = 1'b1;
    n = 0;
    while (green === 1'b1 && n < 40) begin
      step();
      n++;
    end
    total++;
    if (n != 10) begin
      bad++;
      $display("FAIL pause_resume: got %0d edges want 10", n);
    end
  endtask

  task automatic test_reset_mid_yellow();
    int n;
    do_reset();
    enable = 1'b1;
    n = 0;
    while (!(ph == 2 && el == 3) && n < 100) begin
      step();
      n++;
    end
    total++;
    if (yellow !== 1'b1) begin
      bad++;
      $display("FAIL yellow_setup: got yellow=%b want 1", yellow);
    end
    #2 reset_n = 1'b0;
    ph = 0;
    el = 0;
    #1;
    total++;
    if ({red, yellow, green} !== 3'b100 || dut.state !== 2'b00) begin
      bad++;
      $display("FAIL async_reset: got lamps=%b state=%b want 100 00", {red, yellow, green}, dut.state);
    end
    #1 reset_n = 1'b1;
    n = 0;
    while (green !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    total++;
    if (n != 32) begin
      bad++;
      $display("FAIL red_after_reset: got %0d edges want 32", n);
    end
  endtask

  task automatic test_random();
    logic [1:0] prev;
    int n;
    do_reset();
    changes = 0;
    prev = 2'b00;
    n = 0;
    while (changes < 9 && n < 3000) begin
      enable = 1'($urandom % 2);
      step();
      n++;
      total++;
      if (red + yellow + green !== 2'd1 || {red, yellow, green} !== (ph == 0 ? 3'b100 : ph == 1 ? 3'b001 : 3'b010)) begin
        bad++;
        $display("FAIL random_lamps: step %0d got %b want phase %0d", n, {red, yellow, green}, ph);
      end
      total++;
      if (dut.state !== prev && dut.state !== (prev == 2'b00 ? 2'b01 : prev == 2'b01 ? 2'b10 : 2'b00)) begin
        bad++;
        $display("FAIL random_order: got %b after %b", dut.state, prev);
      end
      prev = dut.state;
    end
    total++;
    if (changes < 9) begin
      bad++;
      $display("FAIL random_budget: got %0d phase changes want 9", changes);
    end
  endtask

`ifdef TRAFFIC_LIGHT_COUNT_OUT_EN
  task automatic test_count_out();
    do_reset();
    enable = 1'b1;
    total++;
    if (count_out !== 6'd0) begin
      bad++;
      $display("FAIL count_start: got %0d want 0", count_out);
    end
    for (int n = 1; n <= 59; n++) begin
      step();
      total++;
      if (count_out !== 6'(el)) begin
        bad++;
        $display("FAIL count_out: edge %0d got %0d want %0d", n, count_out, el);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_cycle();
    test_pause();
    test_reset_mid_yellow();
    test_random();
`ifdef TRAFFIC_LIGHT_COUNT_OUT_EN
    test_count_out();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/traffic_light.md
TRAFFIC_LIGHT -- requirements
Module: traffic_light

Interface
REQ-001 The block SHALL have parameter RED_CYCLES, default 32, giving the number of enabled cycles spent in red.
REQ-002 The block SHALL have parameter GREEN_CYCLES, default 20, giving the number of enabled cycles spent in green.
REQ-003 The block SHALL have parameter YELLOW_CYCLES, default 7, giving the number of enabled cycles spent in yellow.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port enable, input, 1 bit: high advances the phase timer; low freezes state and timer.
REQ-007 The block SHALL have port red, output, 1 bit: red lamp.
REQ-008 The block SHALL have port yellow, output, 1 bit: yellow lamp.
REQ-009 The block SHALL have port green, output, 1 bit: green lamp.
REQ-010 The block SHALL hold its phase in an internal 2-bit register named state (S_RED=2'b00, S_GREEN=2'b01, S_YELLOW=2'b10), readable hierarchically by benches.

Function
REQ-011 The phase sequence SHALL be S_RED -> S_GREEN -> S_YELLOW -> S_RED, repeating; no other transitions.
REQ-012 A 6-bit phase counter SHALL increment on each rising edge where enable=1 and the count is below the current phase duration minus 1.
REQ-013 When enable=1 and count = duration-1, the next edge SHALL move to the next phase and clear count to 0; each phase therefore lasts exactly its duration in enabled cycles.
REQ-014 When enable=0, state and count SHALL hold unchanged, with no limit on pause length.
REQ-015 Outputs SHALL be Moore, decoded from state only: S_RED -> red=1, S_GREEN -> green=1, S_YELLOW -> yellow=1; the other two outputs are 0.
REQ-016 Exactly one lamp output SHALL be high at all times, including during and immediately after reset.
REQ-017 The illegal encoding 2'b11 SHALL drive red=1 and move to S_RED with count 0 on the next edge, regardless of enable.
REQ-018 Parameters SHALL be in the range 1..63; a duration of 1 SHALL give a one-enabled-cycle phase.

Reset
REQ-019 reset_n=0 SHALL immediately, without waiting for clk, force state=S_RED, count=0, red=1, yellow=0, green=0.
REQ-020 Reset asserted mid-phase SHALL discard the partial count; after release, timing SHALL restart with a full RED_CYCLES red phase.
REQ-021 The first rising edge with reset_n=1 SHALL be treated as a normal cycle subject to enable.

Configuration
REQ-022 With macro TRAFFIC_LIGHT_COUNT_OUT_EN defined, the block SHALL add output port count_out [5:0], equal to the internal phase counter.
REQ-023 Without TRAFFIC_LIGHT_COUNT_OUT_EN, the port SHALL be absent; all other behaviour SHALL be identical in both builds.

Verification
REQ-024 Hold reset_n=0, enable=0, then release -> red=1, yellow=0, green=0, state=00; state unchanged over 10 cycles with enable=0.
REQ-025 Hold enable=1 from release -> red for 32 edges, green=1 after edge 32, yellow=1 after edge 52, red=1 again after edge 59.
REQ-026 Drop enable for 15 cycles at green count 10 -> green and count hold; green then ends after exactly 10 more enabled edges.
REQ-027 Pulse reset_n low between clock edges during yellow -> red=1 immediately; the next full red phase lasts 32 enabled edges.
REQ-028 Run 3 full cycles with random enable and check every cycle -> exactly one lamp high, and the phase order is never violated.
REQ-029 With TRAFFIC_LIGHT_COUNT_OUT_EN defined -> count_out runs 0..31 in red, 0..19 in green, and 0..6 in yellow.
